uart_rx_ctrl: RTL
=================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, receive FIFO entry count (power of two, 2..16).
REQ-002 baud_clk  input  1  sole clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 frame_done  input  1  SIPO frame-complete flag (level, high >=1 cycle per frame).
REQ-005 frame  input  11  SIPO parallel frame; [10]=start, [9:2]=d0..d7 (d0 first on line), [1]=parity, [0]=stop.
REQ-006 parity_type  input  2  00 none, 01 odd, 10 even, 11 none; sampled at frame capture.
REQ-007 rx_ready  input  1  host accepts rx_data when rx_valid&rx_ready.
REQ-008 err_clr  input  1  one-cycle pulse clearing sticky error flags.
REQ-009 rx_data  output  8  FIFO head byte, bit0=d0.
REQ-010 rx_valid  output  1  FIFO non-empty.
REQ-011 parity_err, frame_err, overrun  output  1 each  sticky error flags.
REQ-012 busy  output  1  high when FSM not in IDLE or FIFO non-empty.

Function
REQ-013 FSM states IDLE, CAPTURE, CHECK, PUSH; IDLE->CAPTURE only on frame_done rising edge (registered previous value), CAPTURE->CHECK->PUSH->IDLE unconditionally.
REQ-014 CAPTURE registers frame and parity_type; frame_done held high SHALL produce exactly one capture.
REQ-015 CHECK: frame_err = (start!=0)|(stop!=1); parity_err = odd ? ^{d,p}!=1 : even ? ^{d,p}!=0 : 0.
REQ-016 PUSH writes byte to FIFO only if no frame or parity error on that frame; errored frames are discarded and set their sticky flag.
REQ-017 PUSH with FIFO full discards byte, sets overrun, FIFO content unchanged.
REQ-018 Latency: frame_done rise sampled at edge N -> rx_valid high after edge N+3 when FIFO was empty.
REQ-019 Pop on rx_valid&rx_ready; simultaneous push and pop when full SHALL succeed (pop first, no overrun).
REQ-020 rx_ready while empty SHALL be ignored; rx_data holds last head value.
REQ-021 Read/write pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1.
REQ-022 err_clr clears all sticky flags; an error set in the same cycle wins.
REQ-023 frame_done rising edge while FSM not IDLE SHALL be ignored and set overrun.

Reset
REQ-024 reset_n low: FSM IDLE, FIFO empty, pointers 0, rx_data 0, rx_valid 0, all error flags 0, busy 0, edge register 0.
REQ-025 Reset mid-frame or mid-PUSH SHALL abandon the frame with no FIFO write after release.
REQ-026 First capture after release requires a fresh frame_done rising edge.

Configuration
REQ-027 Macro UART_RX_CTRL_FIFO_EN defined: DEPTH-entry FIFO per REQ-016..021.
REQ-028 Macro undefined: single holding register (DEPTH ignored), overrun when PUSH finds it occupied and not popped that cycle.

Structure
REQ-029 Shared package uart_pkg holds FSM state enum, parity_type encodings, frame bit-position constants.
REQ-030 One sub-module uart_rx_fifo (DEPTH, 8-bit, full/empty, push/pop) instantiated only under UART_RX_CTRL_FIFO_EN.

Verification
REQ-031 Frame 0_01010101_1_1 (d=0xAA), odd parity, rx_ready=1 -> rx_data=0xAA, one pop, no errors.
REQ-032 Same data, parity bit 0, even parity... -> byte accepted; parity bit 1, even -> parity_err=1, FIFO empty.
REQ-033 Stop bit 0 -> frame_err=1, no push; err_clr pulse -> frame_err=0.
REQ-034 rx_ready=0, DEPTH+1 valid frames -> first DEPTH bytes retained in order, overrun=1.
REQ-035 frame_done held high 5 cycles -> exactly one FIFO entry.
REQ-036 reset_n low during CHECK -> after release rx_valid=0, all flags 0, next frame received normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM state encoding,
// parity_type encodings, SIPO frame bit positions and small frame helpers.
package uart_pkg;

   // SIPO frame layout: [10]=start, [9:2]=d0..d7 (d0 first on line), [1]=parity, [0]=stop
   localparam int FRAME_W       = 11;
   localparam int FRM_START_POS = 10;
   localparam int FRM_D0_POS    = 9;
   localparam int FRM_D7_POS    = 2;
   localparam int FRM_PAR_POS   = 1;
   localparam int FRM_STOP_POS  = 0;

   // parity_type encodings; both 00 and 11 mean "no parity check"
   localparam logic [1:0] PAR_NONE     = 2'b00;
   localparam logic [1:0] PAR_ODD      = 2'b01;
   localparam logic [1:0] PAR_EVEN     = 2'b10;
   localparam logic [1:0] PAR_NONE_ALT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_CHECK   = 2'd2,
      ST_PUSH    = 2'd3
   } rx_state_e;

   // Data bits sit in line order from FRM_D0_POS downwards, so the byte is bit-reversed
   function automatic logic [7:0] frame_data(input logic [FRAME_W-1:0] f);
      logic [7:0] d;
      for (int i = 0; i < 8; i++) begin
         d[i] = f[FRM_D0_POS - i];
      end
      return d;
   endfunction

   // High when the received parity bit disagrees with the selected parity mode
   function automatic logic parity_bad(input logic [7:0] d, input logic p, input logic [1:0] pt);
      logic r;
      r = 1'b0;
      case (pt)
         PAR_ODD:  r = ~(^{d, p});
         PAR_EVEN: r = ^{d, p};
         default:  r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for uart_rx_ctrl (used only when UART_RX_CTRL_FIFO_EN is defined).
// DEPTH entries, registered head output, push accepted when full if a pop
// happens in the same cycle (pop is served first).
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             pop_ok, push_ok;

   // Pointer/count update; the head register tracks whatever sits at the next read pointer
   always_comb begin
      pop_ok   = pop & (count_q != '0);
      push_ok  = push & ((count_q != FULL_CNT) | pop_ok);
      rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      count_d  = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      dout_d = dout_q;
      if (count_d != '0) begin
         // A push landing on the new head slot means the FIFO was empty there: bypass din
         if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            dout_d = din;
         end else begin
            dout_d = mem[rd_ptr_d];
         end
      end
   end

   // Storage array, no reset so it maps onto distributed/block RAM
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= din;
      end
   end

   // Control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
      end
   end

   assign dout  = dout_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: takes SIPO frames, checks start/stop/parity,
// and queues good bytes for the host with sticky error reporting.
// Build option: define UART_RX_CTRL_FIFO_EN for a DEPTH-entry receive FIFO;
// otherwise a single holding register is used and DEPTH is ignored.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               baud_clk,
   input  logic               reset_n,
   input  logic               frame_done,
   input  logic [FRAME_W-1:0] frame,
   input  logic [1:0]         parity_type,
   input  logic               rx_ready,
   input  logic               err_clr,
   output logic [7:0]         rx_data,
   output logic               rx_valid,
   output logic               parity_err,
   output logic               frame_err,
   output logic               overrun,
   output logic               busy
);

   rx_state_e          state_q, state_d;
   logic               fd_prev_q, fd_prev_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [1:0]         ptype_q, ptype_d;
   logic [7:0]         data_q, data_d;
   logic               perr_q, perr_d;
   logic               ferr_q, ferr_d;
   logic               parity_err_q, parity_err_d;
   logic               frame_err_q, frame_err_d;
   logic               overrun_q, overrun_d;

   logic               fd_rise;
   logic [7:0]         cap_data;
   logic               push_req;
   logic               pop;
   logic               store_full;
   logic               push_drop;

   assign fd_rise  = frame_done & ~fd_prev_q;
   assign cap_data = frame_data(frame_q);
   assign push_req = (state_q == ST_PUSH) & ~perr_q & ~ferr_q;
   assign pop      = rx_ready & rx_valid;

   // Frame sequencing: IDLE -> CAPTURE -> CHECK -> PUSH -> IDLE
   always_comb begin
      state_d   = state_q;
      fd_prev_d = frame_done;
      frame_d   = frame_q;
      ptype_d   = ptype_q;
      data_d    = data_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      case (state_q)
         ST_IDLE: begin
            if (fd_rise) begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            frame_d = frame;
            ptype_d = parity_type;
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            data_d  = cap_data;
            ferr_d  = (frame_q[FRM_START_POS] != 1'b0) | (frame_q[FRM_STOP_POS] != 1'b1);
            perr_d  = parity_bad(cap_data, frame_q[FRM_PAR_POS], ptype_q);
            state_d = ST_PUSH;
         end
         ST_PUSH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sticky flags: a set in the same cycle as err_clr takes priority
   always_comb begin
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      overrun_d    = overrun_q;
      if (err_clr) begin
         parity_err_d = 1'b0;
         frame_err_d  = 1'b0;
         overrun_d    = 1'b0;
      end
      if ((state_q == ST_PUSH) && perr_q) begin
         parity_err_d = 1'b1;
      end
      if ((state_q == ST_PUSH) && ferr_q) begin
         frame_err_d = 1'b1;
      end
      if (push_drop || (fd_rise && (state_q != ST_IDLE))) begin
         overrun_d = 1'b1;
      end
   end

   // FSM, captured frame and error flag registers
   always_ff @(posedge baud_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         fd_prev_q    <= 1'b0;
         frame_q      <= '0;
         ptype_q      <= PAR_NONE;
         data_q       <= '0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         fd_prev_q    <= fd_prev_d;
         frame_q      <= frame_d;
         ptype_q      <= ptype_d;
         data_q       <= data_d;
         perr_q       <= perr_d;
         ferr_q       <= ferr_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

`ifdef UART_RX_CTRL_FIFO_EN
   logic fifo_empty;

   uart_rx_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (baud_clk),
      .rst_n (reset_n),
      .push  (push_req),
      .din   (data_q),
      .pop   (pop),
      .dout  (rx_data),
      .empty (fifo_empty),
      .full  (store_full)
   );

   assign rx_valid = ~fifo_empty;
`else
   logic       hold_valid_q, hold_valid_d;
   logic [7:0] hold_data_q, hold_data_d;
   logic       depth_unused;

   assign depth_unused = (DEPTH > 0);

   // Single holding register: a pop in the same cycle frees it for the incoming byte
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      if (pop) begin
         hold_valid_d = 1'b0;
      end
      if (push_req && (!hold_valid_q || pop)) begin
         hold_valid_d = 1'b1;
         hold_data_d  = data_q;
      end
   end

   // Holding register state
   always_ff @(posedge baud_clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
      end
   end

   assign rx_valid   = hold_valid_q;
   assign rx_data    = hold_data_q;
   assign store_full = hold_valid_q;
`endif

   assign push_drop  = push_req & store_full & ~pop;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != ST_IDLE) | rx_valid;

endmodule
